// File: rtl/reg_read_pkg.sv
// Shared constants and helpers for the register-read / hazard stage.
package reg_read_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned NREGS = 32;

  // ADDI x0, x0, 0 in {opcode, funct3, funct7} packing
  localparam logic [16:0] NOP_OPCODE = 17'h04C00;

  function automatic logic [NREGS-1:0] reg_mask(input logic en, input logic [REG_W-1:0] idx);
    reg_mask = '0;
    if (en) reg_mask[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_read_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never busy.
// Effective busy masks out registers being written back in the current cycle.
module reg_read_scoreboard
  import reg_read_pkg::*;
#(
  parameter int unsigned COP_NUMS = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear,
  input  logic                      set_main,
  input  logic [REG_W-1:0]          set_main_idx,
  input  logic [COP_NUMS-1:0]       set_cop,
  input  logic [REG_W*COP_NUMS-1:0] set_cop_idx,
  input  logic                      clr_a,
  input  logic [REG_W-1:0]          clr_a_idx,
  input  logic                      clr_b,
  input  logic [REG_W-1:0]          clr_b_idx,
  input  logic [REG_W-1:0]          look_a_idx,
  input  logic [REG_W-1:0]          look_b_idx,
  output logic                      look_a_busy,
  output logic                      look_b_busy,
  output logic [NREGS-1:0]          eff_busy
);

  logic [NREGS-1:0] busy_q, busy_d, set_mask, clr_mask;

  always_comb begin
    clr_mask = reg_mask(clr_a, clr_a_idx) | reg_mask(clr_b, clr_b_idx);
    set_mask = reg_mask(set_main, set_main_idx);
    for (int unsigned i = 0; i < COP_NUMS; i++) begin
      set_mask = set_mask | reg_mask(set_cop[i], set_cop_idx[i*REG_W +: REG_W]);
    end
    // set is applied after clear so a same-cycle set wins
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  assign eff_busy    = busy_q & ~clr_mask;
  assign look_a_busy = eff_busy[look_a_idx];
  assign look_b_busy = eff_busy[look_b_idx];

  always_ff @(posedge CLK) begin
    if (RST || clear) busy_q <= '0;
    else              busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_read.sv
// Register-read and hazard stage: reads operands with writeback forwarding, checks the
// scoreboard, and either issues to execute or inserts a bubble and stalls the scheduler.
module reg_read
  import reg_read_pkg::*;
#(
  parameter int unsigned COP_NUMS = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      FLUSH,
  input  logic                      STALL,
  input  logic                      MMU_WAIT,
  input  logic                      SCHEDULE_MAIN_ALLOW,
  input  logic [XLEN-1:0]           SCHEDULE_MAIN_PC,
  input  logic [16:0]               SCHEDULE_MAIN_OPCODE,
  input  logic [REG_W-1:0]          SCHEDULE_MAIN_RD,
  input  logic [REG_W-1:0]          SCHEDULE_MAIN_RS1,
  input  logic [REG_W-1:0]          SCHEDULE_MAIN_RS2,
  input  logic [11:0]               SCHEDULE_MAIN_CSR,
  input  logic [XLEN-1:0]           SCHEDULE_MAIN_IMM,
  input  logic [COP_NUMS-1:0]       SCHEDULE_COP_ALLOW,
  input  logic [REG_W*COP_NUMS-1:0] SCHEDULE_COP_RD,
  output logic [REG_W-1:0]          REG_RS1_ADDR,
  output logic [REG_W-1:0]          REG_RS2_ADDR,
  input  logic [XLEN-1:0]           REG_RS1_DATA,
  input  logic [XLEN-1:0]           REG_RS2_DATA,
  input  logic                      WB_MAIN_VALID,
  input  logic [REG_W-1:0]          WB_MAIN_RD,
  input  logic [XLEN-1:0]           WB_MAIN_DATA,
  input  logic                      WB_COP_VALID,
  input  logic [REG_W-1:0]          WB_COP_RD,
  input  logic [XLEN-1:0]           WB_COP_DATA,
  output logic                      HAZARD_STALL,
  output logic                      RR_VALID,
  output logic [XLEN-1:0]           RR_PC,
  output logic [16:0]               RR_OPCODE,
  output logic [REG_W-1:0]          RR_RD,
  output logic [11:0]               RR_CSR,
  output logic [XLEN-1:0]           RR_IMM,
  output logic [XLEN-1:0]           RR_RS1_DATA,
  output logic [XLEN-1:0]           RR_RS2_DATA
);

  logic                hold, hazard, hazard_main, hazard_cop, issue;
  logic                rs1_busy, rs2_busy, set_main;
  logic [COP_NUMS-1:0] set_cop;
  logic [NREGS-1:0]    eff_busy;
  logic [XLEN-1:0]     rs1_val, rs2_val;

  assign REG_RS1_ADDR = SCHEDULE_MAIN_RS1;
  assign REG_RS2_ADDR = SCHEDULE_MAIN_RS2;

  assign hold = STALL | MMU_WAIT;

  always_comb begin
    hazard_cop = 1'b0;
    set_cop    = '0;
    for (int unsigned i = 0; i < COP_NUMS; i++) begin
      if (SCHEDULE_COP_ALLOW[i] && eff_busy[SCHEDULE_COP_RD[i*REG_W +: REG_W]]) begin
        hazard_cop = 1'b1;
      end
      set_cop[i] = issue && SCHEDULE_COP_ALLOW[i] && (SCHEDULE_COP_RD[i*REG_W +: REG_W] != '0);
    end
  end

  assign hazard_main = SCHEDULE_MAIN_ALLOW & (rs1_busy | rs2_busy | eff_busy[SCHEDULE_MAIN_RD]);
  assign hazard      = hazard_main | hazard_cop;
  assign HAZARD_STALL = hazard & ~hold;

  assign issue    = ~hold & ~hazard & ~FLUSH;
  assign set_main = issue & SCHEDULE_MAIN_ALLOW & (SCHEDULE_MAIN_RD != '0);

  reg_read_scoreboard #(
    .COP_NUMS (COP_NUMS)
  ) u_sb (
    .CLK          (CLK),
    .RST          (RST),
    .clear        (FLUSH),
    .set_main     (set_main),
    .set_main_idx (SCHEDULE_MAIN_RD),
    .set_cop      (set_cop),
    .set_cop_idx  (SCHEDULE_COP_RD),
    .clr_a        (WB_MAIN_VALID),
    .clr_a_idx    (WB_MAIN_RD),
    .clr_b        (WB_COP_VALID),
    .clr_b_idx    (WB_COP_RD),
    .look_a_idx   (SCHEDULE_MAIN_RS1),
    .look_b_idx   (SCHEDULE_MAIN_RS2),
    .look_a_busy  (rs1_busy),
    .look_b_busy  (rs2_busy),
    .eff_busy     (eff_busy)
  );

  // Operand priority: x0, main writeback, coprocessor writeback, register file
  always_comb begin
    if (SCHEDULE_MAIN_RS1 == '0)                         rs1_val = '0;
    else if (WB_MAIN_VALID && WB_MAIN_RD == SCHEDULE_MAIN_RS1) rs1_val = WB_MAIN_DATA;
    else if (WB_COP_VALID && WB_COP_RD == SCHEDULE_MAIN_RS1)   rs1_val = WB_COP_DATA;
    else                                                 rs1_val = REG_RS1_DATA;

    if (SCHEDULE_MAIN_RS2 == '0)                         rs2_val = '0;
    else if (WB_MAIN_VALID && WB_MAIN_RD == SCHEDULE_MAIN_RS2) rs2_val = WB_MAIN_DATA;
    else if (WB_COP_VALID && WB_COP_RD == SCHEDULE_MAIN_RS2)   rs2_val = WB_COP_DATA;
    else                                                 rs2_val = REG_RS2_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      RR_VALID    <= 1'b0;
      RR_PC       <= '0;
      RR_OPCODE   <= NOP_OPCODE;
      RR_RD       <= '0;
      RR_CSR      <= '0;
      RR_IMM      <= '0;
      RR_RS1_DATA <= '0;
      RR_RS2_DATA <= '0;
    end else if (!hold) begin
      if (hazard) begin
        RR_VALID  <= 1'b0;
        RR_OPCODE <= NOP_OPCODE;
      end else begin
        RR_VALID    <= SCHEDULE_MAIN_ALLOW;
        RR_PC       <= SCHEDULE_MAIN_PC;
        RR_OPCODE   <= SCHEDULE_MAIN_OPCODE;
        RR_RD       <= SCHEDULE_MAIN_RD;
        RR_CSR      <= SCHEDULE_MAIN_CSR;
        RR_IMM      <= SCHEDULE_MAIN_IMM;
        RR_RS1_DATA <= rs1_val;
        RR_RS2_DATA <= rs2_val;
      end
    end
  end

endmodule

// File: tb/tb_reg_read.sv
// Directed bench for reg_read: a per-cycle vector table plus stall/flush/reset sequences.
module tb_reg_read;
  import reg_read_pkg::*;

  localparam int unsigned COP_NUMS = 1;
  localparam logic [16:0] OPC_A = 17'h0CC00;
  localparam int NV = 18;

  logic CLK = 1'b0;
  logic RST, FLUSH, STALL, MMU_WAIT;
  logic SCHEDULE_MAIN_ALLOW;
  logic [31:0] SCHEDULE_MAIN_PC, SCHEDULE_MAIN_IMM;
  logic [16:0] SCHEDULE_MAIN_OPCODE;
  logic [4:0]  SCHEDULE_MAIN_RD, SCHEDULE_MAIN_RS1, SCHEDULE_MAIN_RS2;
  logic [11:0] SCHEDULE_MAIN_CSR;
  logic [COP_NUMS-1:0]   SCHEDULE_COP_ALLOW;
  logic [5*COP_NUMS-1:0] SCHEDULE_COP_RD;
  logic [4:0]  REG_RS1_ADDR, REG_RS2_ADDR;
  logic [31:0] REG_RS1_DATA, REG_RS2_DATA;
  logic        WB_MAIN_VALID, WB_COP_VALID;
  logic [4:0]  WB_MAIN_RD, WB_COP_RD;
  logic [31:0] WB_MAIN_DATA, WB_COP_DATA;
  logic        HAZARD_STALL, RR_VALID;
  logic [31:0] RR_PC, RR_IMM, RR_RS1_DATA, RR_RS2_DATA;
  logic [16:0] RR_OPCODE;
  logic [4:0]  RR_RD;
  logic [11:0] RR_CSR;

  logic [31:0] rf [32];

  always #5 CLK = ~CLK;

  assign REG_RS1_DATA = rf[REG_RS1_ADDR];
  assign REG_RS2_DATA = rf[REG_RS2_ADDR];

  reg_read #(
    .COP_NUMS (COP_NUMS)
  ) u_dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .FLUSH                (FLUSH),
    .STALL                (STALL),
    .MMU_WAIT             (MMU_WAIT),
    .SCHEDULE_MAIN_ALLOW  (SCHEDULE_MAIN_ALLOW),
    .SCHEDULE_MAIN_PC     (SCHEDULE_MAIN_PC),
    .SCHEDULE_MAIN_OPCODE (SCHEDULE_MAIN_OPCODE),
    .SCHEDULE_MAIN_RD     (SCHEDULE_MAIN_RD),
    .SCHEDULE_MAIN_RS1    (SCHEDULE_MAIN_RS1),
    .SCHEDULE_MAIN_RS2    (SCHEDULE_MAIN_RS2),
    .SCHEDULE_MAIN_CSR    (SCHEDULE_MAIN_CSR),
    .SCHEDULE_MAIN_IMM    (SCHEDULE_MAIN_IMM),
    .SCHEDULE_COP_ALLOW   (SCHEDULE_COP_ALLOW),
    .SCHEDULE_COP_RD      (SCHEDULE_COP_RD),
    .REG_RS1_ADDR         (REG_RS1_ADDR),
    .REG_RS2_ADDR         (REG_RS2_ADDR),
    .REG_RS1_DATA         (REG_RS1_DATA),
    .REG_RS2_DATA         (REG_RS2_DATA),
    .WB_MAIN_VALID        (WB_MAIN_VALID),
    .WB_MAIN_RD           (WB_MAIN_RD),
    .WB_MAIN_DATA         (WB_MAIN_DATA),
    .WB_COP_VALID         (WB_COP_VALID),
    .WB_COP_RD            (WB_COP_RD),
    .WB_COP_DATA          (WB_COP_DATA),
    .HAZARD_STALL         (HAZARD_STALL),
    .RR_VALID             (RR_VALID),
    .RR_PC                (RR_PC),
    .RR_OPCODE            (RR_OPCODE),
    .RR_RD                (RR_RD),
    .RR_CSR               (RR_CSR),
    .RR_IMM               (RR_IMM),
    .RR_RS1_DATA          (RR_RS1_DATA),
    .RR_RS2_DATA          (RR_RS2_DATA)
  );

  typedef struct {
    logic        allow;
    logic [4:0]  rd, rs1, rs2;
    logic        cop;
    logic [4:0]  cop_rd;
    logic        wbm;
    logic [4:0]  wbm_rd;
    logic [31:0] wbm_d;
    logic        wbc;
    logic [4:0]  wbc_rd;
    logic [31:0] wbc_d;
    logic        hz, v;
    logic [31:0] e1, e2;
    logic [4:0]  erd;
  } vec_t;

  vec_t tbl [NV];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(input int al, rd, rs1, rs2, cop, crd, wm, wmrd,
                              input logic [31:0] wmd, input int wc, wcrd,
                              input logic [31:0] wcd, input int hz, v,
                              input logic [31:0] e1, e2, input int erd);
    vec_t m;
    m.allow = al[0];   m.rd = rd[4:0];   m.rs1 = rs1[4:0];  m.rs2 = rs2[4:0];
    m.cop = cop[0];    m.cop_rd = crd[4:0];
    m.wbm = wm[0];     m.wbm_rd = wmrd[4:0]; m.wbm_d = wmd;
    m.wbc = wc[0];     m.wbc_rd = wcrd[4:0]; m.wbc_d = wcd;
    m.hz = hz[0];      m.v = v[0];  m.e1 = e1;  m.e2 = e2;  m.erd = erd[4:0];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive_idle();
    STALL = 1'b0; MMU_WAIT = 1'b0; FLUSH = 1'b0;
    SCHEDULE_MAIN_ALLOW = 1'b0; SCHEDULE_MAIN_PC = '0; SCHEDULE_MAIN_OPCODE = NOP_OPCODE;
    SCHEDULE_MAIN_RD = '0; SCHEDULE_MAIN_RS1 = '0; SCHEDULE_MAIN_RS2 = '0;
    SCHEDULE_MAIN_CSR = '0; SCHEDULE_MAIN_IMM = '0;
    SCHEDULE_COP_ALLOW = '0; SCHEDULE_COP_RD = '0;
    WB_MAIN_VALID = 1'b0; WB_MAIN_RD = '0; WB_MAIN_DATA = '0;
    WB_COP_VALID = 1'b0; WB_COP_RD = '0; WB_COP_DATA = '0;
  endtask

  task automatic main(input logic al, input logic [4:0] rd, rs1, rs2, input int idx);
    SCHEDULE_MAIN_ALLOW  = al;
    SCHEDULE_MAIN_RD     = rd;
    SCHEDULE_MAIN_RS1    = rs1;
    SCHEDULE_MAIN_RS2    = rs2;
    SCHEDULE_MAIN_OPCODE = al ? OPC_A : NOP_OPCODE;
    SCHEDULE_MAIN_PC     = 32'h1000 + 32'(4 * idx);
    SCHEDULE_MAIN_IMM    = 32'(idx);
    SCHEDULE_MAIN_CSR    = 12'(idx);
  endtask

  // Check HAZARD_STALL mid-cycle, then the registered outputs just after the edge.
  task automatic cycle(input string nm, input logic ehz, input logic ev,
                       input logic [31:0] e1, e2, input logic [4:0] erd);
    #3;
    chk({nm, " hazard_stall"}, 32'(HAZARD_STALL), 32'(ehz));
    @(posedge CLK);
    #1;
    chk({nm, " rr_valid"}, 32'(RR_VALID), 32'(ev));
    chk({nm, " rr_opcode"}, 32'(RR_OPCODE), 32'(ev ? OPC_A : NOP_OPCODE));
    chk({nm, " rs1_data"}, RR_RS1_DATA, e1);
    chk({nm, " rs2_data"}, RR_RS2_DATA, e2);
    chk({nm, " rr_rd"}, 32'(RR_RD), 32'(erd));
  endtask

  initial begin
    rf[0] = 32'hFFFF_FFFF;
    for (int i = 1; i < 32; i++) rf[i] = 32'(i * 10);

    //            al rd rs1 rs2 cop crd wm wmrd wmd    wc wcrd wcd    hz v  e1     e2  erd
    tbl[0]  = mk(1, 5, 1, 2,   0, 0,  0, 0, 0,       0, 0, 0,       0, 1, 10,    20, 5);
    tbl[1]  = mk(1, 6, 5, 0,   0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 10,    20, 5);
    tbl[2]  = mk(1, 6, 5, 0,   0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 10,    20, 5);
    tbl[3]  = mk(1, 6, 5, 0,   0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 10,    20, 5);
    tbl[4]  = mk(1, 6, 5, 0,   0, 0,  1, 5, 32'hAB,  0, 0, 0,       0, 1, 'hAB,  0,  6);
    tbl[5]  = mk(1, 0, 7, 7,   0, 0,  1, 7, 32'h1,   1, 7, 32'h2,   0, 1, 1,     1,  0);
    tbl[6]  = mk(1, 8, 0, 3,   0, 0,  1, 6, 32'h66,  0, 0, 0,       0, 1, 0,     30, 8);
    tbl[7]  = mk(1, 0, 0, 0,   0, 0,  0, 0, 0,       0, 0, 0,       0, 1, 0,     0,  0);
    tbl[8]  = mk(0, 0, 0, 0,   1, 9,  0, 0, 0,       0, 0, 0,       0, 0, 0,     0,  0);
    tbl[9]  = mk(1, 10, 9, 0,  0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 0,     0,  0);
    tbl[10] = mk(1, 10, 9, 0,  0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 0,     0,  0);
    tbl[11] = mk(1, 10, 9, 0,  0, 0,  0, 0, 0,       1, 9, 32'h99,  0, 1, 'h99,  0,  10);
    tbl[12] = mk(1, 8, 1, 2,   0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 'h99,  0,  10);
    tbl[13] = mk(1, 8, 1, 2,   0, 0,  1, 8, 32'h88,  0, 0, 0,       0, 1, 10,    20, 8);
    tbl[14] = mk(1, 11, 8, 0,  0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 10,    20, 8);
    tbl[15] = mk(0, 0, 0, 0,   1, 10, 0, 0, 0,       0, 0, 0,       1, 0, 10,    20, 8);
    tbl[16] = mk(0, 0, 0, 0,   1, 10, 0, 0, 0,       1, 10, 32'h5,  0, 0, 0,     0,  0);
    tbl[17] = mk(1, 12, 3, 4,  0, 0,  0, 0, 0,       0, 0, 0,       0, 1, 30,    40, 12);

    drive_idle();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset rr_valid", 32'(RR_VALID), 32'd0);
    chk("reset rr_opcode", 32'(RR_OPCODE), 32'(NOP_OPCODE));
    chk("reset rr_pc", RR_PC, 32'd0);
    chk("reset rs1_data", RR_RS1_DATA, 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive_idle();
      main(tbl[i].allow, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, i);
      SCHEDULE_COP_ALLOW = tbl[i].cop;
      SCHEDULE_COP_RD    = tbl[i].cop_rd;
      WB_MAIN_VALID = tbl[i].wbm; WB_MAIN_RD = tbl[i].wbm_rd; WB_MAIN_DATA = tbl[i].wbm_d;
      WB_COP_VALID  = tbl[i].wbc; WB_COP_RD  = tbl[i].wbc_rd; WB_COP_DATA  = tbl[i].wbc_d;
      cycle($sformatf("vec%0d", i), tbl[i].hz, tbl[i].v, tbl[i].e1, tbl[i].e2, tbl[i].erd);
      if (tbl[i].v) begin
        chk($sformatf("vec%0d rr_pc", i), RR_PC, 32'h1000 + 32'(4 * i));
        chk($sformatf("vec%0d rr_imm", i), RR_IMM, 32'(i));
        chk($sformatf("vec%0d rr_csr", i), 32'(RR_CSR), 32'(i));
      end
    end

    // STALL then MMU_WAIT: outputs frozen, hazard suppressed, writeback clear still lands
    drive_idle();
    STALL = 1'b1;
    main(1'b1, 5'd13, 5'd12, 5'd2, 30);
    WB_MAIN_VALID = 1'b1; WB_MAIN_RD = 5'd10;
    cycle("stall1", 1'b0, 1'b1, 32'd30, 32'd40, 5'd12);
    chk("stall1 rr_pc", RR_PC, 32'h1044);
    drive_idle();
    MMU_WAIT = 1'b1;
    main(1'b1, 5'd13, 5'd12, 5'd2, 31);
    cycle("stall2", 1'b0, 1'b1, 32'd30, 32'd40, 5'd12);
    chk("stall2 rr_pc", RR_PC, 32'h1044);
    drive_idle();
    main(1'b1, 5'd13, 5'd10, 5'd0, 32);
    cycle("post_stall", 1'b0, 1'b1, 32'd100, 32'd0, 5'd13);

    // FLUSH while x8 is pending: bubble now, everything free next cycle
    drive_idle();
    FLUSH = 1'b1;
    main(1'b1, 5'd14, 5'd8, 5'd12, 33);
    cycle("flush", 1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
    chk("flush rr_pc", RR_PC, 32'd0);
    drive_idle();
    main(1'b1, 5'd14, 5'd8, 5'd12, 34);
    cycle("post_flush", 1'b0, 1'b1, 32'd80, 32'd120, 5'd14);

    // Reset during a hazard behaves like FLUSH
    drive_idle();
    main(1'b1, 5'd15, 5'd14, 5'd0, 35);
    cycle("rst_haz", 1'b1, 1'b0, 32'd80, 32'd120, 5'd14);
    drive_idle();
    RST = 1'b1;
    main(1'b1, 5'd15, 5'd14, 5'd0, 36);
    cycle("rst_mid", 1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
    drive_idle();
    RST = 1'b0;
    main(1'b1, 5'd15, 5'd14, 5'd0, 37);
    cycle("post_rst", 1'b0, 1'b1, 32'd140, 32'd0, 5'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
